// File: rtl/tracking_pkg.sv
// Shared types and helpers for the colour-blob tracker.
package tracking_pkg;

    localparam int COORD_W = 12;

    typedef logic [COORD_W-1:0] coord_t;

    // BMP byte order: blue in the top byte, red in the bottom byte.
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

    typedef struct packed {
        coord_t min_x;
        coord_t max_x;
        coord_t min_y;
        coord_t max_y;
        logic   nonempty;
    } bbox_t;

    localparam bbox_t BBOX_EMPTY = '0;

    // Strong green with weak red and blue.
    function automatic logic is_green(input pixel_t p, input logic [7:0] g_min,
                                      input logic [7:0] other_max);
        return (p.g >= g_min) && (p.r < other_max) && (p.b < other_max);
    endfunction

endpackage

// File: rtl/tracking_if.sv
// Pixel input and frame-result bundle for the tracker.
interface tracking_if;
    import tracking_pkg::*;

    logic   in_wr_en;
    pixel_t in_din;
    logic   in_full;
    logic   valid;
    coord_t center_x;
    coord_t center_y;
    coord_t width;
    coord_t height;

    modport master (
        output in_wr_en, in_din,
        input  in_full, valid, center_x, center_y, width, height
    );

    modport slave (
        input  in_wr_en, in_din,
        output in_full, valid, center_x, center_y, width, height
    );

endinterface

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray-coded pointers and two-flop synchronizers.
// The read port is first-word-fall-through: dout is valid while empty is low.
module async_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 32
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_bin, wr_gray, wr_bin_next;
    ptr_t rd_bin, rd_gray, rd_bin_next;
    ptr_t rd_gray_w1, rd_gray_w2;
    ptr_t wr_gray_r1, wr_gray_r2;
    logic wr_inc, rd_inc;

    assign wr_inc      = wr_en && !full;
    assign rd_inc      = rd_en && !empty;
    assign wr_bin_next = wr_bin + ptr_t'(wr_inc);
    assign rd_bin_next = rd_bin + ptr_t'(rd_inc);

    // Full when the write pointer has lapped the synchronized read pointer once.
    assign full  = (wr_gray == {~rd_gray_w2[AW:AW-1], rd_gray_w2[AW-2:0]});
    assign empty = (rd_gray == wr_gray_r2);
    assign dout  = mem[rd_bin[AW-1:0]];

    // Write pointer, kept in binary for addressing and Gray for crossing.
    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            wr_bin  <= '0;
            wr_gray <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, like real hardware.
            wr_bin  <= wr_bin_next;
            wr_gray <= wr_bin_next ^ (wr_bin_next >> 1);
        end
    end

    // Storage write; the array holds no reset since empty/full gate all use of it.
    always_ff @(posedge wr_clk) begin
        // NOTE: memories are left unreset so they map onto RAM; pointers alone define contents.
        if (wr_inc) begin
            mem[wr_bin[AW-1:0]] <= din;
        end
    end

    // Bring the read pointer into the write domain.
    always_ff @(posedge wr_clk or negedge reset) begin
        if (!reset) begin
            rd_gray_w1 <= '0;
            rd_gray_w2 <= '0;
        end else begin
            rd_gray_w1 <= rd_gray;
            rd_gray_w2 <= rd_gray_w1;
        end
    end

    // Read pointer, advanced on every pop.
    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            rd_bin  <= '0;
            rd_gray <= '0;
        end else begin
            rd_bin  <= rd_bin_next;
            rd_gray <= rd_bin_next ^ (rd_bin_next >> 1);
        end
    end

    // Bring the write pointer into the read domain.
    always_ff @(posedge rd_clk or negedge reset) begin
        if (!reset) begin
            wr_gray_r1 <= '0;
            wr_gray_r2 <= '0;
        end else begin
            wr_gray_r1 <= wr_gray;
            wr_gray_r2 <= wr_gray_r1;
        end
    end

endmodule

// File: rtl/tracking_top.sv
// Green-blob tracker: classifies each popped pixel, tracks the bounding box
// over one raster frame and reports centre and size once per frame.
module tracking_top #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int FIFO_DEPTH = 32,
    parameter int GREEN_MIN  = 200,
    parameter int OTHER_MAX  = 64
) (
    input logic       clock_50,
    input logic       clock_25,
    input logic       reset,
    tracking_if.slave bus
);

    import tracking_pkg::*;

    localparam coord_t LAST_COL = coord_t'(WIDTH - 1);
    localparam coord_t LAST_ROW = coord_t'(HEIGHT - 1);

    logic [23:0] fifo_dout;
    logic        fifo_empty;
    logic        pop;
    logic        green;
    logic        frame_end;
    pixel_t      px;
    coord_t      col, row;
    bbox_t       box, box_next;
    coord_t      cx_calc, cy_calc, w_calc, h_calc;
    logic [COORD_W:0] sum_x, sum_y;

    async_fifo #(
        .DATA_WIDTH(24),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .wr_clk(clock_25),
        .rd_clk(clock_50),
        .reset (reset),
        .wr_en (bus.in_wr_en),
        .din   (bus.in_din),
        .full  (bus.in_full),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign pop       = !fifo_empty;
    assign px        = pixel_t'(fifo_dout);
    assign green     = pop && is_green(px, 8'(GREEN_MIN), 8'(OTHER_MAX));
    assign frame_end = pop && (col == LAST_COL) && (row == LAST_ROW);

    // Box including the pixel being consumed this cycle.
    always_comb begin
        // NOTE: default first so every path assigns box_next and no latch is inferred.
        box_next = box;
        if (green) begin
            if (!box.nonempty) begin
                box_next.min_x    = col;
                box_next.max_x    = col;
                box_next.min_y    = row;
                box_next.max_y    = row;
                box_next.nonempty = 1'b1;
            end else begin
                if (col < box.min_x) box_next.min_x = col;
                if (col > box.max_x) box_next.max_x = col;
                if (row < box.min_y) box_next.min_y = row;
                if (row > box.max_y) box_next.max_y = row;
            end
        end
    end

    // Frame results from the final box; an empty frame reports all zeros.
    always_comb begin
        sum_x   = {1'b0, box_next.min_x} + {1'b0, box_next.max_x};
        sum_y   = {1'b0, box_next.min_y} + {1'b0, box_next.max_y};
        cx_calc = '0;
        cy_calc = '0;
        w_calc  = '0;
        h_calc  = '0;
        if (box_next.nonempty) begin
            cx_calc = sum_x[COORD_W:1];
            cy_calc = sum_y[COORD_W:1];
            w_calc  = box_next.max_x - box_next.min_x + coord_t'(1);
            h_calc  = box_next.max_y - box_next.min_y + coord_t'(1);
        end
    end

    // Raster position and running box; the box restarts empty after the last pixel.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
            box <= BBOX_EMPTY;
        end else if (pop) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + coord_t'(1);
            end else begin
                col <= col + coord_t'(1);
            end
            box <= frame_end ? BBOX_EMPTY : box_next;
        end
    end

    // Registered results: one-cycle valid, values held until the next frame end.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            bus.valid    <= 1'b0;
            bus.center_x <= '0;
            bus.center_y <= '0;
            bus.width    <= '0;
            bus.height   <= '0;
        end else begin
            bus.valid <= frame_end;
            if (frame_end) begin
                bus.center_x <= cx_calc;
                bus.center_y <= cy_calc;
                bus.width    <= w_calc;
                bus.height   <= h_calc;
            end
        end
    end

endmodule

// File: tb/tb_tracking_top.sv
// Bench for tracking_top. The frame is shrunk to 24x24 so whole frames stream quickly;
// the same corner, threshold and reset cases apply at that size.
module tb_tracking_top;
    import tracking_pkg::*;

    localparam int W  = 24;
    localparam int H  = 24;
    localparam int FD = 32;

    logic clock_50 = 1'b0;
    logic clock_25 = 1'b0;
    logic reset    = 1'b0;
    bit   clk50_en = 1'b1;

    tracking_if bus ();

    tracking_top #(
        .WIDTH     (W),
        .HEIGHT    (H),
        .FIFO_DEPTH(FD),
        .GREEN_MIN (200),
        .OTHER_MAX (64)
    ) dut (
        .clock_50(clock_50),
        .clock_25(clock_25),
        .reset   (reset),
        .bus     (bus)
    );

    always #10 if (clk50_en) clock_50 = ~clock_50;

    initial begin
        #5;
        forever #20 clock_25 = ~clock_25;
    end

    typedef struct {
        coord_t cx, cy, w, h;
        longint cyc;
    } res_t;

    typedef struct {
        string       name;
        int          rx0, ry0, rx1, ry1;
        int          sx, sy;
        logic [23:0] fg;
        int          nred;
        int          ecx, ecy, ew, eh;
    } vec_t;

    res_t   got[$];
    longint cyc50 = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    // Collect every valid pulse with its clock_50 timestamp.
    always @(negedge clock_50) begin
        cyc50++;
        if (bus.valid) got.push_back('{bus.center_x, bus.center_y, bus.width, bus.height, cyc50});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input vec_t v, input int x, input int y);
        if (x >= v.rx0 && x <= v.rx1 && y >= v.ry0 && y <= v.ry1) return v.fg;
        if (x == v.sx && y == v.sy) return v.fg;
        if (y * W + x < v.nred) return 24'h0000FF;
        return 24'h000000;
    endfunction

    task automatic write_px(input logic [23:0] d);
        int guard = 0;
        while (bus.in_full && guard < 1000) begin
            @(posedge clock_25); #1;
            guard++;
        end
        if (guard >= 1000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL write_wait: in_full stuck at %0d, expected 0", bus.in_full);
        end
        bus.in_din   = d;
        bus.in_wr_en = 1'b1;
        @(posedge clock_25); #1;
        bus.in_wr_en = 1'b0;
    endtask

    task automatic send_range(input vec_t v, input int first, input int last);
        for (int i = first; i <= last; i++) write_px(pix(v, i % W, i / W));
    endtask

    task automatic blind_writes(input int n, input logic [23:0] d);
        bus.in_din   = d;
        bus.in_wr_en = 1'b1;
        repeat (n) @(posedge clock_25);
        #1;
        bus.in_wr_en = 1'b0;
    endtask

    task automatic wait_pulses(input string name, input int n);
        int g = 0;
        while (got.size() < n && g < 5000) begin
            @(negedge clock_50);
            g++;
        end
        repeat (4) @(negedge clock_50);
        check({name, ".pulses"}, 32'(got.size()), 32'(n));
    endtask

    task automatic expect_res(input string name, input int idx,
                              input int ecx, input int ecy, input int ew, input int eh);
        if (got.size() > idx) begin
            check({name, ".center_x"}, 32'(got[idx].cx), 32'(ecx));
            check({name, ".center_y"}, 32'(got[idx].cy), 32'(ecy));
            check({name, ".width"},    32'(got[idx].w),  32'(ew));
            check({name, ".height"},   32'(got[idx].h),  32'(eh));
        end
    endtask

    task automatic gate_clock_50();
        @(negedge clock_50);
        clk50_en = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int base;

        //           name          rx0 ry0 rx1 ry1  sx  sy  fg            nred  cx  cy  w   h
        vecs[0] = '{"block",       12,  4, 15,  7, -1, -1, 24'h00FF00,  0, 13,  5,  4,  4};
        vecs[1] = '{"no_green",    -1, -1, -2, -2, -1, -1, 24'h00FF00, 10,  0,  0,  0,  0};
        vecs[2] = '{"corners",     23, 23, 23, 23,  0,  0, 24'h00FF00,  0, 11, 11, 24, 24};
        vecs[3] = '{"g199",         5,  5,  8,  8, -1, -1, 24'h00C700,  0,  0,  0,  0,  0};
        vecs[4] = '{"g200_rb63",   10, 20, 10, 20, -1, -1, 24'h3FC83F,  0, 10, 20,  1,  1};
        vecs[5] = '{"r64",          3,  3,  6,  6, -1, -1, 24'h00C840,  0,  0,  0,  0,  0};
        vecs[6] = '{"b64",          3,  3,  6,  6, -1, -1, 24'h40C800,  0,  0,  0,  0,  0};
        vecs[7] = '{"bottom_row",   0, 23, 23, 23, -1, -1, 24'h00FF00,  0, 11, 23, 24,  1};

        bus.in_wr_en = 1'b0;
        bus.in_din   = '0;

        // Reset state.
        #200;
        check("reset.valid",    32'(bus.valid),    0);
        check("reset.in_full",  32'(bus.in_full),  0);
        check("reset.center_x", 32'(bus.center_x), 0);
        check("reset.center_y", 32'(bus.center_y), 0);
        check("reset.width",    32'(bus.width),    0);
        check("reset.height",   32'(bus.height),   0);
        @(negedge clock_25);
        reset = 1'b1;
        repeat (4) @(negedge clock_50);

        // One frame per table entry.
        for (int i = 0; i < 8; i++) begin
            base = got.size();
            send_range(vecs[i], 0, W * H - 1);
            wait_pulses(vecs[i].name, base + 1);
            expect_res(vecs[i].name, base, vecs[i].ecx, vecs[i].ecy, vecs[i].ew, vecs[i].eh);
        end

        // Three back-to-back frames: identical results, one frame of pops apart.
        base = got.size();
        repeat (3) send_range(vecs[0], 0, W * H - 1);
        wait_pulses("stream3", base + 3);
        for (int k = 0; k < 3; k++) expect_res($sformatf("stream3[%0d]", k), base + k, 13, 5, 4, 4);
        if (got.size() >= base + 3) begin
            check("stream3.gap01", 32'(got[base + 1].cyc - got[base].cyc),     32'(2 * W * H));
            check("stream3.gap12", 32'(got[base + 2].cyc - got[base + 1].cyc), 32'(2 * W * H));
        end

        // Fill the FIFO with the reader stalled; extra writes must be dropped.
        base = got.size();
        gate_clock_50();
        send_range(vecs[4], 0, FD - 1);
        check("full.after_fill", 32'(bus.in_full), 1);
        blind_writes(8, 24'h00FF00);
        check("full.still_set", 32'(bus.in_full), 1);
        clk50_en = 1'b1;
        send_range(vecs[4], FD, W * H - 1);
        wait_pulses("full_drop", base + 1);
        expect_res("full_drop", base, 10, 20, 1, 1);

        // Reset mid-frame with a full FIFO, then a clean frame.
        for (int i = 0; i < 50; i++) write_px(24'h00FF00);
        repeat (10) @(negedge clock_50);
        gate_clock_50();
        blind_writes(40, 24'h00FF00);
        check("rst.full_before", 32'(bus.in_full), 1);
        reset = 1'b0;
        #100;
        check("rst.in_full",  32'(bus.in_full),  0);
        check("rst.valid",    32'(bus.valid),    0);
        check("rst.center_x", 32'(bus.center_x), 0);
        check("rst.center_y", 32'(bus.center_y), 0);
        check("rst.width",    32'(bus.width),    0);
        check("rst.height",   32'(bus.height),   0);
        clk50_en = 1'b1;
        repeat (4) @(negedge clock_50);
        @(negedge clock_25);
        reset = 1'b1;
        repeat (4) @(negedge clock_50);
        base = got.size();
        send_range(vecs[0], 0, W * H - 1);
        wait_pulses("after_reset", base + 1);
        expect_res("after_reset", base, 13, 5, 4, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
